// File: rtl/bpred_update_ctrl_if.sv
// Branch-predictor update bus: resolved-branch requesters on one side,
// the predictor table write port and predictor status on the other.
interface bpred_update_ctrl_if #(
    parameter int NUM_REQ = 2,
    parameter int PC_W    = 32,
    parameter int IDX_W   = 6
);
    logic                    flush_i;
    logic [NUM_REQ-1:0]      upd_valid_i;
    logic [NUM_REQ-1:0]      upd_ready_o;
    logic [NUM_REQ*PC_W-1:0] upd_pc_i;
    logic [NUM_REQ*PC_W-1:0] upd_target_i;
    logic [NUM_REQ-1:0]      upd_taken_i;
    logic                    tbl_we_o;
    logic                    tbl_ready_i;
    logic                    tbl_clear_o;
    logic [IDX_W-1:0]        tbl_idx_o;
    logic [PC_W-1:0]         tbl_pc_o;
    logic [PC_W-1:0]         tbl_target_o;
    logic                    tbl_taken_o;
    logic                    pred_en_o;
    logic                    busy_o;

    // Requesters, table and fetch drive this side.
    modport master (
        output flush_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, tbl_ready_i,
        input  upd_ready_o, tbl_we_o, tbl_clear_o, tbl_idx_o, tbl_pc_o,
               tbl_target_o, tbl_taken_o, pred_en_o, busy_o
    );

    // The update controller sits on this side.
    modport slave (
        input  flush_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, tbl_ready_i,
        output upd_ready_o, tbl_we_o, tbl_clear_o, tbl_idx_o, tbl_pc_o,
               tbl_target_o, tbl_taken_o, pred_en_o, busy_o
    );
endinterface

// File: rtl/bpred_update_ctrl.sv
// Branch-predictor table update controller.
// CLEAR walks every table entry and invalidates it; RUN round-robin
// arbitrates resolved-branch updates into a small FIFO and drains the FIFO
// into the single table write port. A flush restarts the clear walk.
module bpred_update_ctrl #(
    parameter int NUM_REQ    = 2,
    parameter int ENTRIES    = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int PC_W       = 32
) (
    input logic                clk,
    input logic                rst,
    bpred_update_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [RR_W-1:0]  rr_q, rr_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Payload storage carries no reset; only the pointers/count qualify it.
    logic [PC_W-1:0]       fifo_pc     [FIFO_DEPTH];
    logic [PC_W-1:0]       fifo_target [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_taken;

    logic               fifo_empty, fifo_full;
    logic               push, pop;
    logic [NUM_REQ-1:0] grant;
    logic [RR_W-1:0]    gnt_idx;
    logic [PC_W-1:0]    head_pc, head_target;
    logic               head_taken;

    logic               tbl_we, tbl_clear, tbl_taken, pred_en, busy;
    logic [IDX_W-1:0]   tbl_idx;
    logic [PC_W-1:0]    tbl_pc, tbl_target;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign head_pc     = fifo_pc[rd_ptr_q];
    assign head_target = fifo_target[rd_ptr_q];
    assign head_taken  = fifo_taken[rd_ptr_q];

    // Round-robin grant: first valid requester at or above the pointer, wrapping.
    // Full FIFO blocks every grant even if the head pops this cycle.
    always_comb begin
        logic [RR_W:0] cand;
        logic          found;
        grant   = '0;
        gnt_idx = rr_q;
        found   = 1'b0;
        cand    = '0;
        if (!rst && state_q == RUN && !bus.flush_i && !fifo_full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_q} + (RR_W+1)'(k);
                if (cand >= (RR_W+1)'(NUM_REQ)) cand = cand - (RR_W+1)'(NUM_REQ);
                if (!found && bus.upd_valid_i[cand[RR_W-1:0]]) begin
                    found   = 1'b1;
                    gnt_idx = cand[RR_W-1:0];
                end
            end
            if (found) grant[gnt_idx] = 1'b1;
        end
    end

    assign push = |grant;
    assign pop  = !rst && (state_q == RUN) && !fifo_empty && bus.tbl_ready_i;

    // Pointer advances past the granted requester; holds when nothing is granted.
    always_comb begin
        rr_d = rr_q;
        if (push) rr_d = (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Next-state and table-port outputs; everything reads 0 while rst is high.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        tbl_we     = 1'b0;
        tbl_clear  = 1'b0;
        tbl_idx    = '0;
        tbl_pc     = '0;
        tbl_target = '0;
        tbl_taken  = 1'b0;
        pred_en    = 1'b0;
        busy       = 1'b0;
        if (!rst) begin
            case (state_q)
                CLEAR: begin
                    tbl_we    = 1'b1;
                    tbl_clear = 1'b1;
                    tbl_idx   = clr_cnt_q;
                    busy      = 1'b1;
                    if (bus.tbl_ready_i) begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                        if (clr_cnt_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
                    end
                end
                RUN: begin
                    pred_en = 1'b1;
                    busy    = !fifo_empty;
                    tbl_we  = !fifo_empty;
                    if (!fifo_empty) begin
                        tbl_idx    = head_pc[IDX_W+1:2];
                        tbl_pc     = head_pc;
                        tbl_target = head_target;
                        tbl_taken  = head_taken;
                    end
                end
                default: state_d = CLEAR;
            endcase
            if (bus.flush_i) begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        end
    end

    // Control state register: FSM state, clear-walk index, arbiter pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_q      <= rr_d;
        end
    end

    // FIFO pointers and occupancy; a flush discards every pending update.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO payload write for the granted requester.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]     <= bus.upd_pc_i[int'(gnt_idx)*PC_W +: PC_W];
            fifo_target[wr_ptr_q] <= bus.upd_target_i[int'(gnt_idx)*PC_W +: PC_W];
            fifo_taken[wr_ptr_q]  <= bus.upd_taken_i[gnt_idx];
        end
    end

    assign bus.upd_ready_o  = grant;
    assign bus.tbl_we_o     = tbl_we;
    assign bus.tbl_clear_o  = tbl_clear;
    assign bus.tbl_idx_o    = tbl_idx;
    assign bus.tbl_pc_o     = tbl_pc;
    assign bus.tbl_target_o = tbl_target;
    assign bus.tbl_taken_o  = tbl_taken;
    assign bus.pred_en_o    = pred_en;
    assign bus.busy_o       = busy;
endmodule

// File: doc/bpred_update_ctrl.md
Name: bpred_update_ctrl

Overview:
- Sequences every write into the branch-predictor tables (BTB/direction) that sit beside fetch.
- After reset or flush it walks and clears every table entry, holding predictions off until the walk completes.
- In normal operation it round-robin arbitrates resolved-branch updates from NUM_REQ branch units into a small FIFO.
- It drains that FIFO into the single table write port whenever the table accepts a write.

Parameters:
- NUM_REQ, 2, number of branch-resolution requesters (≥1).
- ENTRIES, 64, table entries; power of 2; IDX_W = log2(ENTRIES).
- FIFO_DEPTH, 4, pending-update buffer depth; power of 2, ≥2.
- PC_W, 32, PC/target width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  request full table re-clear.
- upd_valid_i  in  NUM_REQ  per-requester update valid.
- upd_ready_o  out  NUM_REQ  per-requester grant; transfer when valid&ready.
- upd_pc_i  in  NUM_REQ*PC_W  branch PC, requester i at bits [i*PC_W +: PC_W].
- upd_target_i  in  NUM_REQ*PC_W  resolved target, same packing.
- upd_taken_i  in  NUM_REQ  resolved direction.
- tbl_we_o  out  1  table write request.
- tbl_ready_i  in  1  table accepts write this cycle (port free of fetch read).
- tbl_clear_o  out  1  write invalidates entry (valid bit = 0).
- tbl_idx_o  out  IDX_W  entry index.
- tbl_pc_o  out  PC_W  tag source PC.
- tbl_target_o  out  PC_W  target to store.
- tbl_taken_o  out  1  direction to store.
- pred_en_o  out  1  predictor contents valid; fetch must ignore predictions when 0.
- busy_o  out  1  clear walk in progress or FIFO non-empty.

Behaviour:
- State machine: CLEAR, RUN.
- Reset (rst=1 at a clock edge): state=CLEAR, clear counter=0, FIFO empty, RR pointer=0.
- While rst is high, all outputs read 0.
- CLEAR:
  - tbl_we_o=1, tbl_clear_o=1, tbl_idx_o=counter; tbl_pc_o/tbl_target_o/tbl_taken_o=0.
  - upd_ready_o=0; pred_en_o=0; busy_o=1.
  - The counter advances only on a cycle where tbl_ready_i=1.
  - A write with tbl_ready_i=1 at counter=ENTRIES-1 moves to RUN next cycle.
  - Minimum walk: ENTRIES cycles.
- RUN:
  - pred_en_o=1.
  - Write port: tbl_we_o=!fifo_empty, tbl_clear_o=0, fields from FIFO head, tbl_idx_o=head_pc[IDX_W+1:2].
  - Head pops when tbl_we_o&tbl_ready_i.
- Arbiter (RUN, flush_i=0, FIFO count<FIFO_DEPTH):
  - At most one upd_ready_o bit high per cycle: the first valid requester searching from the RR pointer upward, wrapping.
  - upd_ready_o is never high for a requester whose valid is low.
  - After a grant to i, RR pointer = (i+1) mod NUM_REQ; with no grant the pointer holds.
  - Full FIFO: all ready=0, even if a pop occurs the same cycle (conservative).
  - upd_ready_o is combinational from valid, pointer and count; there is no valid→ready loop on the requester side.
- Latency: an update accepted at cycle t is presented on tbl_we_o no earlier than t+1. Same-cycle push and pop are allowed; count is unchanged.
- FIFO order: strict acceptance order, pointers wrap modulo FIFO_DEPTH.
- Flush:
  - flush_i=1 in any state forces upd_ready_o=0 that cycle.
  - Next cycle: FIFO emptied (pending updates discarded), counter=0, state=CLEAR, pred_en_o=0. RR pointer is kept.
  - A write issued in the flush cycle itself (tbl_we_o&tbl_ready_i) still completes.
  - Flush during CLEAR restarts the walk at index 0.
  - Flush held high keeps the walk at index 0.
- rst has priority over flush_i.
- busy_o = (state==CLEAR) | !fifo_empty.

Test Plan:
- Reset release, ENTRIES=64, tbl_ready_i=1 → cycles 1–64: tbl_we_o=tbl_clear_o=1, idx 0..63; cycle 65: pred_en_o=1, busy_o=0.
- Clear walk with tbl_ready_i toggling 1,0,1,0 → idx holds on stalled cycles; walk completes after exactly 128 cycles.
- RUN, both requesters valid continuously, tbl_ready_i=1 → grants alternate 0,1,0,1; table writes follow one cycle later in the same order; idx=pc[7:2] (e.g. pc 0x1004 → idx 1).
- RUN, tbl_ready_i=0, requester 0 valid → 4 accepts fill FIFO; upd_ready_o=0 from the 5th cycle. Set tbl_ready_i=1 → 4 writes in order, then accepts resume.
- FIFO holds 3 entries, flush_i pulse → no further update writes; next cycle CLEAR at idx 0, pred_en_o=0; after 64 ready cycles RUN with FIFO empty.
- flush_i asserted mid-walk at idx 30 → next cycle idx 0, the walk restarts, pred_en_o stays 0 throughout.
